// File: rtl/sync_debounce_edge.sv
// sync_debounce_edge: debounce a synchronized level, emit edge pulses and a saturating rise count
module sync_debounce_edge #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_in,
  input  logic             clr_count,
  output logic             db_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] edge_count
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  typedef enum logic [1:0] {LOW_STABLE, RISE_PEND, HIGH_STABLE, FALL_PEND} state_t;
  state_t state, state_nx;
  logic [CW-1:0] ctr, ctr_nx;
  logic db_nx, rise_nx, fall_nx;
  // state, stability counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOW_STABLE;
      ctr <= '0;
      db_out <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state <= state_nx;
      ctr <= ctr_nx;
      db_out <= db_nx;
      rise_pulse <= rise_nx;
      fall_pulse <= fall_nx;
    end
  end
  // qualify a new level only after STABLE_CYCLES identical consecutive samples
  always_comb begin
    state_nx = state;
    ctr_nx = ctr;
    db_nx = db_out;
    rise_nx = 1'b0;
    fall_nx = 1'b0;
    case (state)
      LOW_STABLE: if (sync_in) begin
        state_nx = RISE_PEND;
        ctr_nx = CW'(1);
      end
      RISE_PEND: if (!sync_in) begin
        state_nx = LOW_STABLE;
        ctr_nx = '0;
      end else if (ctr == LAST) begin
        state_nx = HIGH_STABLE;
        ctr_nx = '0;
        db_nx = 1'b1;
        rise_nx = 1'b1;
      end else ctr_nx = ctr + CW'(1);
      HIGH_STABLE: if (!sync_in) begin
        state_nx = FALL_PEND;
        ctr_nx = CW'(1);
      end
      FALL_PEND: if (sync_in) begin
        state_nx = HIGH_STABLE;
        ctr_nx = '0;
      end else if (ctr == LAST) begin
        state_nx = LOW_STABLE;
        ctr_nx = '0;
        db_nx = 1'b0;
        fall_nx = 1'b1;
      end else ctr_nx = ctr + CW'(1);
      default: state_nx = LOW_STABLE;
    endcase
  end
  // saturating rise counter; a clear coinciding with a rise keeps that rise
  always_ff @(posedge clk) begin
    if (!rst_n) edge_count <= '0;
    else if (clr_count) edge_count <= rise_pulse ? CNT_W'(1) : '0;
    else if (rise_pulse && !(&edge_count)) edge_count <= edge_count + CNT_W'(1);
  end
endmodule

// File: tb/tb_sync_debounce_edge.sv
// tb_sync_debounce_edge: vector table plus scoreboard check of the debouncer (CNT_W=8 and CNT_W=2)
module tb_sync_debounce_edge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sync_in = 1'b0;
  logic clr_count = 1'b0;
  logic db8, rise8, fall8, db2, rise2, fall2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
  int n_checks = 0;
  int n_fails = 0;
  typedef struct {
    logic rst_n, s, clr;
    logic db, rise, fall;
    logic [7:0] c8;
    logic [1:0] c2;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  always #5 clk = ~clk;
  sync_debounce_edge #(.STABLE_CYCLES(4), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .sync_in(sync_in), .clr_count(clr_count),
    .db_out(db8), .rise_pulse(rise8), .fall_pulse(fall8), .edge_count(cnt8)
  );
  sync_debounce_edge #(.STABLE_CYCLES(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sync_in(sync_in), .clr_count(clr_count),
    .db_out(db2), .rise_pulse(rise2), .fall_pulse(fall2), .edge_count(cnt2)
  );
  task automatic add(input logic r, s, c, db, ri, fa, input logic [7:0] c8, input logic [1:0] c2);
    vec_t v;
    v.rst_n = r; v.s = s; v.clr = c; v.db = db; v.rise = ri; v.fall = fa; v.c8 = c8; v.c2 = c2;
    tbl.push_back(v);
  endtask
  task automatic addn(input int n, input logic r, s, c, db, ri, fa, input logic [7:0] c8, input logic [1:0] c2);
    for (int i = 0; i < n; i++) add(r, s, c, db, ri, fa, c8, c2);
  endtask
  task automatic chk(input string name, input int step_no, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step_no, act, exp);
    end
  endtask
  task automatic step(input vec_t v, input int k);
    vec_t e;
    @(negedge clk);
    rst_n = v.rst_n;
    sync_in = v.s;
    clr_count = v.clr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("db_out", k, {7'd0, db8}, {7'd0, e.db});
    chk("rise_pulse", k, {7'd0, rise8}, {7'd0, e.rise});
    chk("fall_pulse", k, {7'd0, fall8}, {7'd0, e.fall});
    chk("edge_count8", k, cnt8, e.c8);
    chk("db_out_w2", k, {7'd0, db2}, {7'd0, e.db});
    chk("rise_pulse_w2", k, {7'd0, rise2}, {7'd0, e.rise});
    chk("fall_pulse_w2", k, {7'd0, fall2}, {7'd0, e.fall});
    chk("edge_count2", k, {6'd0, cnt2}, {6'd0, e.c2});
  endtask
  task automatic go(input logic r, s, c, db, ri, fa, input logic [7:0] c8, input logic [1:0] c2, input int k);
    vec_t v;
    v.rst_n = r; v.s = s; v.clr = c; v.db = db; v.rise = ri; v.fall = fa; v.c8 = c8; v.c2 = c2;
    step(v, k);
  endtask
  initial begin
    int k;
    int i2;
    k = 0;
    addn(3, 0, 1, 0, 0, 0, 0, 0, 0);
    addn(3, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 1, 1);
    addn(3, 1, 0, 0, 1, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 1, 1, 1);
    add(1, 0, 0, 0, 0, 0, 1, 1);
    addn(3, 1, 1, 0, 0, 0, 0, 1, 1);
    addn(2, 1, 0, 0, 0, 0, 0, 1, 1);
    addn(3, 1, 1, 0, 0, 0, 0, 1, 1);
    add(1, 1, 0, 1, 1, 0, 1, 1);
    add(1, 1, 0, 1, 0, 0, 2, 2);
    addn(3, 1, 0, 0, 1, 0, 0, 2, 2);
    add(1, 0, 0, 0, 0, 1, 2, 2);
    addn(3, 1, 1, 0, 0, 0, 0, 2, 2);
    add(1, 1, 0, 1, 1, 0, 2, 2);
    add(1, 1, 1, 1, 0, 0, 1, 1);
    add(1, 1, 1, 1, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0, 0);
    addn(3, 1, 0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0);
    addn(2, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    addn(3, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 1, 1);
    addn(3, 1, 0, 0, 1, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 1, 1, 1);
    foreach (tbl[i]) begin
      step(tbl[i], k);
      k++;
    end
    for (int i = 0; i < 50; i++) begin
      go(1, (i % 2 == 0), 0, 0, 0, 0, 8'd1, 2'd1, k);
      k++;
    end
    go(1, 0, 1, 0, 0, 0, 8'd0, 2'd0, k);
    k++;
    for (int i = 0; i < 5; i++) begin
      i2 = (i > 3) ? 3 : i;
      for (int j = 0; j < 4; j++) begin
        go(1, 1, 0, (j == 3), (j == 3), 0, 8'(i), 2'(i2), k);
        k++;
      end
      i2 = (i + 1 > 3) ? 3 : i + 1;
      for (int j = 0; j < 4; j++) begin
        go(1, 0, 0, (j != 3), 0, (j == 3), 8'(i + 1), 2'(i2), k);
        k++;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/sync_debounce_edge.md
Name: sync_debounce_edge

Overview:
- Sits directly downstream of the two-flip-flop synchronizer and consumes its synchronized output `sync_out`.
- Filters glitches by requiring the input to hold a level for STABLE_CYCLES consecutive clocks before accepting it.
- Emits the accepted (debounced) level, single-cycle rise and fall pulses, and a saturating count of accepted rising edges for status logic.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples needed to accept a new level; legal range 2..255.
- CNT_W, 8, width of the edge_count output; legal range 1..32.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- sync_in  input  1  already-synchronized level, driven by the synchronizer's sync_out.
- clr_count  input  1  synchronous clear of edge_count.
- db_out  output  1  debounced level.
- rise_pulse  output  1  one-cycle pulse on each accepted 0->1 transition.
- fall_pulse  output  1  one-cycle pulse on each accepted 1->0 transition.
- edge_count  output  CNT_W  number of accepted rising edges; saturates.

Behaviour:

Clocking and reset
- Single clock domain. Reset is synchronous and active-low: sampled on the rising edge of clk when rst_n=0.
- All outputs are registered.
- Reset values: db_out=0, rise_pulse=0, fall_pulse=0, edge_count=0, FSM=LOW_STABLE, stability counter=0.

FSM states: LOW_STABLE, RISE_PEND, HIGH_STABLE, FALL_PEND. A stability counter `ctr` has width clog2(STABLE_CYCLES+1).
- LOW_STABLE:
  - sync_in=1 -> RISE_PEND, ctr=1.
  - Otherwise stay.
- RISE_PEND:
  - sync_in=0 -> LOW_STABLE, ctr=0; glitch rejected, no output change.
  - sync_in=1 and ctr==STABLE_CYCLES-1 -> HIGH_STABLE; db_out<=1, rise_pulse<=1.
  - Otherwise ctr++.
- HIGH_STABLE and FALL_PEND mirror the above with polarity inverted. The accepting transition drives db_out<=0, fall_pulse<=1.

Timing
- Latency: db_out changes on the STABLE_CYCLES-th consecutive edge that samples the new level. With N=4, a change first sampled at edge k is visible after edge k+3.
- rise_pulse and fall_pulse are high for exactly one cycle, coincident with the db_out change. They are never high together.
- An input pulse held for fewer than STABLE_CYCLES samples produces no output activity.

Edge counter
- edge_count increments by 1 in the cycle rise_pulse is asserted, i.e. the increment is visible on the edge after the pulse.
- Saturates at 2^CNT_W-1 and never wraps.
- clr_count=1 clears edge_count to 0 on the next edge.
- If clr_count and an increment occur in the same cycle, edge_count=1; the event is not lost.
- Falling edges are never counted.

Boundary conditions
- Reset mid-qualification discards all pending state; no pulses are emitted.
- If sync_in is already 1 when rst_n releases, it is treated as a fresh rise. It needs a full STABLE_CYCLES qualification, then emits rise_pulse and increments edge_count.
- Input toggling every cycle indefinitely: db_out holds its level, and no pulses occur.

Test Plan:
- Reset check (STABLE_CYCLES=4, CNT_W=8): hold rst_n=0 for 3 edges with sync_in=1 -> all outputs 0 throughout. Release -> db_out=1 and rise_pulse=1 on the 4th edge after release; edge_count=1 one edge later.
- Glitch rejection: sync_in high for 3 cycles, then low -> db_out stays 0, no pulses, edge_count unchanged. Held 4 cycles -> db_out=1, one rise_pulse.
- Falling edge: from debounced high, drive sync_in=0 for 4 cycles -> db_out=0 with a single fall_pulse on the 4th edge; edge_count unchanged.
- Saturation (CNT_W=2): 5 clean accepted rises -> edge_count reads 1,2,3,3,3.
- clr_count coincident with the rise_pulse cycle at edge_count=2 -> edge_count=1 next edge. clr_count alone -> 0.
- Mid-qualification reset: sync_in high 2 cycles, rst_n=0 for 1 edge, sync_in held high -> no pulse before reset. rise_pulse only after 4 full samples post-release.
- 1-cycle alternating sync_in for 50 cycles -> db_out constant 0, zero pulses.
